// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Load/store sequencer between the CPU datapath and a word-wide DataMemory.
//   It turns byte/halfword/word requests into word-aligned memory cycles.
//   Sub-word stores are done as read-modify-write. Loads come back as a
//   one-cycle response pulse, sign- or zero-extended.
//
//   Optional feature macro: LSU_MISALIGN_TRAP_EN
//     defined   : misaligned halfword/word requests are trapped. They go
//                 straight to RESP with rsp_err=1 and issue no memory cycle.
//     undefined : the offending low address bits are ignored, and rsp_err
//                 always reads 0.
//
//   Ports
//     CLK, Reset              clock and synchronous active-high reset
//     req_valid/we/size/unsigned/addr/wdata
//                             request, sampled only in IDLE
//     busy                    high whenever the FSM is not in IDLE
//     rsp_valid/rdata/err     one-cycle completion pulse with its data and flag
//     DAddr, DataIn, RD, WR   memory side; RD and WR are active low
//     DataOut                 memory read data, combinational while RD=0
module mem_access_unit #(
  parameter int ADDR_W = 32
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              busy,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] DAddr,
  output logic [31:0]       DataIn,
  output logic              RD,
  output logic              WR,
  input  logic [31:0]       DataOut
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  state_t      state_reg;
  logic        we_reg;
  logic [1:0]  size_reg;      // normalised: size 11 is stored as word
  logic        unsigned_reg;
  logic [1:0]  off_reg;       // low address bits of the accepted request
  logic [31:0] wdata_reg;

  logic [1:0]  size_norm;
  logic        misalign;
  logic [1:0]  lane_off;
  logic [4:0]  lane_shift;
  logic [31:0] shifted;
  logic [31:0] load_data;
  logic [31:0] lane_mask;
  logic [31:0] merged;

  assign size_norm = (req_size == 2'b11) ? SZ_WORD : req_size;

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign = ((size_norm == SZ_HALF) && req_addr[0]) ||
                    ((size_norm == SZ_WORD) && (req_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  // Lane selection and extraction use only the latched request fields.
  // Without trapping, a halfword keeps addr[1] and a word is forced to offset 0.
  always_comb begin
    lane_off  = 2'b00;
    load_data = DataOut;
    lane_mask = 32'hFFFF_FFFF;
    case (size_reg)
      SZ_BYTE: lane_off = off_reg;
      SZ_HALF: lane_off = {off_reg[1], 1'b0};
      default: lane_off = 2'b00;
    endcase
    lane_shift = {lane_off, 3'b000};
    shifted    = DataOut >> lane_shift;
    case (size_reg)
      SZ_BYTE: begin
        load_data = unsigned_reg ? {24'h0, shifted[7:0]}
                                 : {{24{shifted[7]}}, shifted[7:0]};
        lane_mask = 32'h0000_00FF << lane_shift;
      end
      SZ_HALF: begin
        load_data = unsigned_reg ? {16'h0, shifted[15:0]}
                                 : {{16{shifted[15]}}, shifted[15:0]};
        lane_mask = 32'h0000_FFFF << lane_shift;
      end
      default: begin
        load_data = DataOut;
        lane_mask = 32'hFFFF_FFFF;
      end
    endcase
    // Read-modify-write: keep the unselected lanes of the word just read.
    merged = (DataOut & ~lane_mask) | ((wdata_reg << lane_shift) & lane_mask);
  end

  // All outputs are registered. Each output is loaded with the value that
  // belongs to the state being entered, so it is valid for that whole cycle.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_reg    <= IDLE;
      we_reg       <= 1'b0;
      size_reg     <= SZ_BYTE;
      unsigned_reg <= 1'b0;
      off_reg      <= 2'b00;
      wdata_reg    <= 32'h0;
      busy         <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= 32'h0;
      rsp_err      <= 1'b0;
      DAddr        <= '0;
      DataIn       <= 32'h0;
      RD           <= 1'b1;
      WR           <= 1'b1;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            we_reg       <= req_we;
            size_reg     <= size_norm;
            unsigned_reg <= req_unsigned;
            off_reg      <= req_addr[1:0];
            wdata_reg    <= req_wdata;
            busy         <= 1'b1;
            if (misalign) begin
              state_reg <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= 32'h0;
            end else if (req_we && (size_norm == SZ_WORD)) begin
              // A full-word store needs no read, so it goes straight to WRITE.
              state_reg <= WRITE;
              DAddr     <= {req_addr[ADDR_W-1:2], 2'b00};
              DataIn    <= req_wdata;
              WR        <= 1'b0;
            end else begin
              state_reg <= READ;
              DAddr     <= {req_addr[ADDR_W-1:2], 2'b00};
              RD        <= 1'b0;
            end
          end
        end
        READ: begin
          RD <= 1'b1;
          if (we_reg) begin
            state_reg <= WRITE;
            DataIn    <= merged;
            WR        <= 1'b0;
          end else begin
            state_reg <= RESP;
            DAddr     <= '0;
            rsp_valid <= 1'b1;
            rsp_rdata <= load_data;
          end
        end
        WRITE: begin
          state_reg <= RESP;
          WR        <= 1'b1;
          DAddr     <= '0;
          DataIn    <= 32'h0;
          rsp_valid <= 1'b1;
          rsp_rdata <= 32'h0;
        end
        default: begin  // RESP
          state_reg <= IDLE;
          busy      <= 1'b0;
          rsp_valid <= 1'b0;
          rsp_rdata <= 32'h0;
          rsp_err   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store sequencer between the CPU datapath and the word-wide `DataMemory`. It accepts byte, halfword and word load/store requests and drives `DataMemory`'s `DAddr`/`DataIn`/`RD`/`WR` with word-aligned accesses. Sub-word stores are done as read-modify-write. Loads are returned sign- or zero-extended as a single-cycle response pulse.

## Interface
Parameters:
- `ADDR_W`, default 32: address width, for both the request and `DAddr`.

Ports:
- `CLK` in 1: clock; all state updates on the rising edge.
- `Reset` in 1: synchronous, active-high reset.
- `req_valid` in 1: request strobe; sampled only when `busy`=0.
- `req_we` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 = byte, 01 = halfword, 10 = word; 11 is treated as word.
- `req_unsigned` in 1: on loads, 1 = zero-extend, 0 = sign-extend.
- `req_addr` in `ADDR_W`: byte address.
- `req_wdata` in 32: store data, right-justified.
- `busy` out 1: high whenever the state is not IDLE.
- `rsp_valid` out 1: one-cycle completion pulse.
- `rsp_rdata` out 32: extended load data; 0 for stores.
- `rsp_err` out 1: misaligned-request flag, valid together with `rsp_valid`.
- `DAddr` out `ADDR_W`: word-aligned memory address, `{req_addr[ADDR_W-1:2], 2'b00}`.
- `DataIn` out 32: memory write data.
- `RD` out 1: active-low read enable to `DataMemory`.
- `WR` out 1: active-low write enable to `DataMemory`.
- `DataOut` in 32: memory read data; combinational while `RD`=0.

## Operation
- Byte lanes are little-endian: offset 0 is bits [7:0], offset 3 is bits [31:24]. A halfword uses lanes {0,1} or {2,3}.
- On acceptance, the request fields are latched. Memory outputs are decoded from the state and the latched fields, never from live inputs.
- The state machine has four states: IDLE, READ, WRITE, RESP.
- IDLE:
  - `RD`=1, `WR`=1, `DAddr`=0, `DataIn`=0.
  - If `req_valid`=1:
    - word store goes to WRITE;
    - sub-word store goes to READ;
    - load goes to READ;
    - misaligned request (see Configuration) goes to RESP with the error flag set.
- READ:
  - `RD`=0, `WR`=1.
  - `DataOut` is captured at the closing edge.
  - Next state is WRITE for a store, RESP for a load.
- WRITE:
  - `WR`=0, `RD`=1.
  - `DataIn` is the captured word with the selected lanes replaced by `req_wdata[7:0]` or `req_wdata[15:0]`, or the whole `req_wdata` for a word store.
  - `DataMemory` commits the write on the falling edge inside this cycle.
  - Next state is RESP.
- RESP:
  - `rsp_valid`=1; `rsp_rdata` and `rsp_err` are valid.
  - Next state is IDLE.
  - On an error, `rsp_rdata`=0 and no memory cycle was issued.
- Load extraction: the selected lane(s) are shifted to bit 0, then zero- or sign-extended to 32 bits.
- `req_valid` while `busy`=1 is ignored; the requester holds the request until it is accepted.
- Reset value of every output: `busy`=0, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, `RD`=1, `WR`=1, `DAddr`=0, `DataIn`=0. The state resets to IDLE.
- Reset mid-operation:
  - The sequence is abandoned and IDLE is entered at the next edge. No response is issued.
  - Reset asserted during a WRITE cycle does not suppress that cycle's falling-edge write, because reset is synchronous.

## Timing
- Acceptance happens at edge E0 (IDLE with `req_valid`=1).
- Load: READ in cycle 1, RESP in cycle 2. `rsp_valid` is high 2 cycles after acceptance.
- Word store: WRITE in cycle 1, RESP in cycle 2.
- Sub-word store: READ in cycle 1, WRITE in cycle 2, RESP in cycle 3.
- Misaligned request (macro defined): RESP in cycle 1.
- A new request can be accepted no earlier than the edge that closes RESP. Peak throughput is one request per 3 cycles; sub-word stores take 4.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - A halfword with `req_addr[0]`=1, or a word with `req_addr[1:0]`≠0, goes IDLE→RESP with `rsp_err`=1.
  - `RD` and `WR` stay 1 for the whole request.
- `LSU_MISALIGN_TRAP_EN` undefined:
  - Offending low address bits are ignored: halfword uses `addr[1]` only, word uses offset 0.
  - `rsp_err` is tied to 0.

## Test plan
- **Reset:** hold `Reset`=1 for 2 cycles → all outputs at their reset values, `RD`=`WR`=1.
- **Word store/load:** store word 0x12345678 to addr 8 → `WR`=0 with `DAddr`=8, `DataIn`=0x12345678 for exactly one cycle, `rsp_valid` 2 cycles after acceptance. Then load word from addr 8 → `rsp_rdata`=0x12345678.
- **Byte store RMW:** memory word at 12 = 0xAABBCCDD; store byte 0x5A to addr 14 → one READ cycle then one WRITE cycle with `DataIn`=0xAA5ACCDD; `rsp_valid` 3 cycles after acceptance.
- **Sign/zero extension:** word at 12 = 0xAA5ACCDD.
  - Load signed byte from addr 13 → 0xFFFFFFCC.
  - Load unsigned halfword from addr 14 → 0x0000AA5A.
- **Misaligned:** load word from addr 6.
  - With `LSU_MISALIGN_TRAP_EN`: `rsp_err`=1 one cycle after acceptance, no `RD` assertion.
  - Without the macro: data from addr 4.
- **Busy and abort:** pulse `req_valid` during READ → ignored, no second access. Assert `Reset` during READ of a byte store → no `WR`=0 cycle occurs, `busy`=0 after the edge.
